// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative radix-2 multiply/divide unit (shift-add multiply,
//               restoring divide) with start/busy/done handshake and cancel.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_zero
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;      // product accumulator; low half doubles as dividend/quotient
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_x_raw;
    logic                 r_y_zero;
    logic                 r_neg_lo;
    logic                 r_neg_hi;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_x_neg;
    logic                 w_y_neg;
    logic [WIDTH-1:0]     w_x_mag;
    logic [WIDTH-1:0]     w_y_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_q_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    // Magnitude of MIN is MIN itself read as unsigned, so no extra bit is needed.
    assign w_x_neg = op[0] & x[WIDTH-1];
    assign w_y_neg = op[0] & y[WIDTH-1];
    assign w_x_mag = w_x_neg ? -x : x;
    assign w_y_mag = w_y_neg ? -y : y;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Partial remainder stays below the divisor, so only the shifted word needs WIDTH+1 bits.
    assign w_div_shift  = {r_rem, r_acc[WIDTH-1]};
    assign w_div_diff   = w_div_shift - {1'b0, r_a};
    assign w_div_ge     = ~w_div_diff[WIDTH];
    assign w_div_q_next = {r_acc[WIDTH-2:0], w_div_ge};

    assign w_prod = r_neg_lo ? -r_acc : r_acc;
    assign w_quo  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? -r_rem : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_a      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_x_raw  <= '0;
            r_y_zero <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        r_op     <= op;
                        r_x_raw  <= x;
                        r_y_zero <= (y == '0);
                        r_neg_lo <= w_x_neg ^ w_y_neg;
                        r_neg_hi <= op[1] ? w_x_neg : (w_x_neg ^ w_y_neg);
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_CALC;
                        if (!op[1]) begin
                            r_a   <= w_x_mag;
                            r_acc <= {{WIDTH{1'b0}}, w_y_mag};
                        end else begin
                            r_a   <= w_y_mag;
                            r_acc <= {{WIDTH{1'b0}}, w_x_mag};
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (!r_op[1]) begin
                            r_acc <= w_mul_next;
                        end else begin
                            r_acc[WIDTH-1:0] <= w_div_q_next;
                            r_rem <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        lo       <= w_prod[WIDTH-1:0];
                        hi       <= w_prod[2*WIDTH-1:WIDTH];
                        div_zero <= 1'b0;
                    end else if (r_y_zero) begin
                        lo       <= r_x_raw;
                        hi       <= '0;
                        div_zero <= 1'b1;
                    end else begin
                        lo       <= w_quo;
                        hi       <= w_rem;
                        div_zero <= 1'b0;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
